ram_input_ctrl: RTL and testbench

- Sequencer and arbiter for the single-port input sample RAM (synchronous write, registered read address, 1-cycle read latency).
- Shares the RAM between two requesters:
  - a host load stream, which fills entries 0..DEPTH-1;
  - a compute read stream, which drains entries 0..DEPTH-1 in order with valid/ready backpressure.
- Sits between the host interface / compute core and the RAM instance; drives the RAM's data, addr and we and consumes its q.

---
 rtl/ram_input_pkg.sv | 16 +
 rtl/ram_input_ctrl_if.sv | 30 +++
 rtl/ram_input_ctrl.sv | 99 +++++++++
 tb/tb_ram_input_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_input_pkg.sv
// Shared definitions for the input sample RAM and its controller:
// the controller state encoding and the default geometry of the RAM.
package ram_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RD_PRIME,
    RD_STREAM
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 1;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_DEPTH      = 784;

endpackage

// File: rtl/ram_input_ctrl_if.sv
// Host load stream and compute read stream seen by ram_input_ctrl.
// The master is the host/compute side; the slave is the controller.
interface ram_input_ctrl_if #(
  parameter int DATA_WIDTH = ram_input_pkg::DEFAULT_DATA_WIDTH
);

  logic                  load_start;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  load_done;
  logic                  rd_start;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_last;
  logic                  rd_done;
  logic                  busy;

  modport master (
    output load_start, wr_data, wr_valid, rd_start, rd_ready,
    input  wr_ready, load_done, rd_data, rd_valid, rd_last, rd_done, busy
  );

  modport slave (
    input  load_start, wr_data, wr_valid, rd_start, rd_ready,
    output wr_ready, load_done, rd_data, rd_valid, rd_last, rd_done, busy
  );

endinterface

// File: rtl/ram_input_ctrl.sv
// Sequencer/arbiter sharing the single-port input sample RAM between the
// host load stream and the in-order compute read stream.
module ram_input_ctrl
  import ram_input_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_input_ctrl_if.slave       bus,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next;
  logic                  load_done_q, load_done_next;
  logic                  rd_done_q, rd_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      load_done_q <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      load_done_q <= load_done_next;
      rd_done_q   <= rd_done_next;
    end
  end

  // In RD_STREAM the address looks one entry ahead on an accept so that
  // ram_q already holds the next sample, giving one sample per cycle.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    load_done_next = 1'b0;
    rd_done_next   = 1'b0;
    ram_addr       = '0;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_next = LOAD;
          ptr_next   = '0;
        end else if (bus.rd_start) begin
          state_next = RD_PRIME;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        ram_addr = ptr;
        if (bus.wr_valid) begin
          if (ptr == LAST) begin
            state_next     = IDLE;
            load_done_next = 1'b1;
          end else begin
            ptr_next = ptr + 1'b1;
          end
        end
      end
      RD_PRIME: begin
        state_next = RD_STREAM;
        ptr_next   = '0;
      end
      RD_STREAM: begin
        ram_addr = ptr;
        if (bus.rd_ready) begin
          if (ptr == LAST) begin
            state_next   = IDLE;
            rd_done_next = 1'b1;
          end else begin
            ptr_next = ptr + 1'b1;
            ram_addr = ptr + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_data      = bus.wr_data;
  assign ram_we        = (state == LOAD) && bus.wr_valid;
  assign bus.wr_ready  = (state == LOAD);
  assign bus.rd_valid  = (state == RD_STREAM);
  assign bus.rd_data   = ram_q;
  assign bus.rd_last   = (state == RD_STREAM) && (ptr == LAST);
  assign bus.busy      = (state != IDLE);
  assign bus.load_done = load_done_q;
  assign bus.rd_done   = rd_done_q;

endmodule

// File: tb/tb_ram_input_ctrl.sv
// Randomized bench for ram_input_ctrl: an array model of the expected RAM
// contents predicts every write address and every streamed read sample.
module tb_ram_input_ctrl;

  localparam int DW    = 1;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int MAX_CYCLES = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [DEPTH];

  ram_input_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ram_input_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_we  (ram_we),
    .ram_q   (ram_q)
  );

  // External single-port RAM: synchronous write, registered read address.
  logic [DW-1:0] ram_mem [2**AW];
  logic [AW-1:0] ram_addr_q = '0;

  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_addr_q <= ram_addr;
  end

  assign ram_q = ram_mem[ram_addr_q];

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: wr_valid held high, 1: one on / two off, 2: random gaps
  task automatic applyStimulus(input int mode, input bit both_starts, input bit inject_rd,
                               input bit chain_read);
    int idx = 0;
    int cyc = 0;
    bit v;
    bus.load_start = 1'b1;
    bus.rd_start   = both_starts;
    #2;
    checkOutput("idle_busy", 32'(bus.busy), 0);
    nextCycle();
    bus.load_start = 1'b0;
    bus.rd_start   = 1'b0;
    while (idx < DEPTH && cyc < MAX_CYCLES) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.wr_valid = v;
      bus.wr_data  = DW'($urandom);
      bus.rd_start = inject_rd && (cyc == 1);
      bus.load_start = 1'($urandom_range(0, 1));
      #2;
      checkOutput("load_wr_ready", 32'(bus.wr_ready), 1);
      checkOutput("load_busy", 32'(bus.busy), 1);
      checkOutput("load_we", 32'(ram_we), 32'(v));
      checkOutput("load_rd_valid", 32'(bus.rd_valid), 0);
      checkOutput("load_done_early", 32'(bus.load_done), 0);
      if (v) begin
        checkOutput("load_addr", 32'(ram_addr), 32'(idx));
        checkOutput("load_data", 32'(ram_data), 32'(bus.wr_data));
        model_mem[idx] = bus.wr_data;
        idx++;
      end
      nextCycle();
      cyc++;
    end
    checkOutput("load_count", 32'(idx), 32'(DEPTH));
    bus.wr_valid   = 1'b0;
    bus.load_start = 1'b0;
    bus.rd_start   = chain_read;
    #2;
    checkOutput("load_done", 32'(bus.load_done), 1);
    checkOutput("load_done_busy", 32'(bus.busy), 0);
    checkOutput("load_done_we", 32'(ram_we), 0);
    nextCycle();
    bus.rd_start = 1'b0;
    if (!chain_read) begin
      for (int i = 0; i < 3; i++) begin
        #2;
        checkOutput("post_load_rd_valid", 32'(bus.rd_valid), 0);
        checkOutput("post_load_busy", 32'(bus.busy), 0);
        checkOutput("post_load_done", 32'(bus.load_done), 0);
        nextCycle();
      end
    end
  endtask

  // ready mode 0: always ready, 1: three-cycle stall on entry 1, 2: random
  task automatic readPass(input int rdy_mode, input bit skip_start, input int abort_idx);
    int idx = 0;
    int cyc = 0;
    int stalls = 0;
    bit rdy;
    bus.rd_ready = 1'b0;
    if (!skip_start) begin
      bus.rd_start = 1'b1;
      #2;
      checkOutput("rd_start_valid", 32'(bus.rd_valid), 0);
      nextCycle();
      bus.rd_start = 1'b0;
    end
    #2;
    checkOutput("prime_busy", 32'(bus.busy), 1);
    checkOutput("prime_valid", 32'(bus.rd_valid), 0);
    checkOutput("prime_addr", 32'(ram_addr), 0);
    checkOutput("prime_we", 32'(ram_we), 0);
    nextCycle();
    while (idx < DEPTH && cyc < MAX_CYCLES) begin
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(idx == 1 && stalls < 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (!rdy) stalls++;
      bus.rd_ready   = rdy;
      bus.rd_start   = 1'($urandom_range(0, 1));
      bus.load_start = 1'($urandom_range(0, 1));
      #2;
      checkOutput("rd_valid", 32'(bus.rd_valid), 1);
      checkOutput("rd_data", 32'(bus.rd_data), 32'(model_mem[idx]));
      checkOutput("rd_last", 32'(bus.rd_last), 32'(idx == DEPTH - 1));
      checkOutput("rd_done_early", 32'(bus.rd_done), 0);
      checkOutput("rd_we", 32'(ram_we), 0);
      if (rdy)
        checkOutput("rd_addr_adv", 32'(ram_addr), 32'((idx == DEPTH - 1) ? idx : idx + 1));
      else
        checkOutput("rd_addr_stall", 32'(ram_addr), 32'(idx));
      if (idx == abort_idx) begin
        rst_n = 1'b0;
        bus.rd_start   = 1'b0;
        bus.load_start = 1'b0;
        #1;
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 0);
        checkOutput("rst_rd_last", 32'(bus.rd_last), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_addr", 32'(ram_addr), 0);
        checkOutput("rst_rd_done", 32'(bus.rd_done), 0);
        nextCycle();
        rst_n = 1'b1;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #2;
          checkOutput("abort_rd_done", 32'(bus.rd_done), 0);
          checkOutput("abort_busy", 32'(bus.busy), 0);
          nextCycle();
        end
        return;
      end
      if (rdy) idx++;
      nextCycle();
      cyc++;
    end
    checkOutput("rd_count", 32'(idx), 32'(DEPTH));
    bus.rd_ready   = 1'b0;
    bus.rd_start   = 1'b0;
    bus.load_start = 1'b0;
    #2;
    checkOutput("rd_done", 32'(bus.rd_done), 1);
    checkOutput("rd_done_busy", 32'(bus.busy), 0);
    checkOutput("rd_done_valid", 32'(bus.rd_valid), 0);
    nextCycle();
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.wr_data    = '0;
    bus.wr_valid   = 1'b0;
    bus.rd_start   = 1'b0;
    bus.rd_ready   = 1'b0;
    #2;
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_wr_ready", 32'(bus.wr_ready), 0);
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 0);
    checkOutput("reset_addr", 32'(ram_addr), 0);
    checkOutput("reset_we", 32'(ram_we), 0);
    checkOutput("reset_done", 32'({bus.load_done, bus.rd_done, bus.rd_last}), 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    readPass(0, 1'b0, -1);
    readPass(1, 1'b0, -1);
    applyStimulus(1, 1'b1, 1'b1, 1'b0);
    readPass(2, 1'b0, -1);
    applyStimulus(2, 1'b0, 1'b0, 1'b1);
    readPass(2, 1'b1, -1);
    readPass(0, 1'b0, 2);
    readPass(0, 1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
      readPass(int'($urandom_range(0, 2)), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
